// File: rtl/apb3_fabric_master.sv
// rtl/apb3_fabric_master.sv - APB3 master bridging a local request/response port onto an APB3 bus
//
// Purpose: accepts one local command at a time, runs it as an APB3 SETUP/ACCESS
// transfer and returns a single-cycle response pulse with read data and error.
//
// Ports:
//   PCLK, PRESET             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      local request handshake (ready only while IDLE)
//   cmd_write/addr/wdata     request fields, captured on the acceptance edge
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata/rsp_err        response fields, held until the next pulse
//   PADDR/PWRITE/PWDATA      APB3 address phase outputs
//   PSEL/PENABLE             APB3 phase controls
//   PRDATA/PREADY/PSLVERR    APB3 slave responses
//
// Configuration:
//   APB3_FABRIC_MASTER_TIMEOUT_EN  adds a 16-bit wait counter that terminates an
//                                  ACCESS phase with an error after TIMEOUT_CYCLES
//                                  PREADY-low cycles.

module apb3_fabric_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("apb3_fabric_master: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic                    pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;
`ifdef APB3_FABRIC_MASTER_TIMEOUT_EN
  localparam logic [15:0]  TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];
  logic [15:0]             wait_cnt_q,  wait_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB3_FABRIC_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Address/data registers only load here, so they stay frozen through
        // the whole transfer and the following IDLE.
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB3_FABRIC_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        // PREADY is checked first so a completion on the limit cycle wins.
        if (PREADY) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end
`ifdef APB3_FABRIC_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LIMIT) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB3_FABRIC_MASTER_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB3_FABRIC_MASTER_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // Gated by reset so the port reads 0 while PRESET is held.
  assign cmd_ready = (state_q == ST_IDLE) && !PRESET;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;

endmodule
